// File: rtl/req_gnt_responder.sv
// Grant-side responder: a sampled req yields a registered grant two cycles later
// held for a clamped MIN_LEN..MAX_LEN window. Optional assertions: REQ_GNT_SVA_EN.
module req_gnt_responder #(
    parameter int unsigned MIN_LEN = 3,
    parameter int unsigned MAX_LEN = 5,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [LEN_W-1:0] gnt_len,
    output logic             grant,
    output logic             busy,
    output logic             gnt_done,
    output logic [CNT_W-1:0] win_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GRANT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               pending_q;
    logic [LEN_W-1:0]   len_d1_q;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               grant_q, grant_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_c;

    // Clamp the requested window length into [MIN_LEN, MAX_LEN]
    always_comb begin
        if (gnt_len < LEN_W'(MIN_LEN)) begin
            len_c = LEN_W'(MIN_LEN);
        end else if (gnt_len > LEN_W'(MAX_LEN)) begin
            len_c = LEN_W'(MAX_LEN);
        end else begin
            len_c = gnt_len;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            len_d1_q  <= '0;
            rem_q     <= '0;
            grant_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= req;
            len_d1_q  <= len_c;
            rem_q     <= rem_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        grant_d = grant_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                grant_d = 1'b0;
                if (req) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_GRANT;
                grant_d = 1'b1;
                rem_d   = len_d1_q - LEN_W'(1);
                cnt_d   = cnt_q + CNT_W'(1);
            end
            S_GRANT: begin
                if (pending_q) begin
                    // A request landed during the window: restart the countdown
                    rem_d = len_d1_q - LEN_W'(1);
                end else if (rem_q != '0) begin
                    rem_d = rem_q - LEN_W'(1);
                end else begin
                    grant_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = req ? S_WAIT : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign gnt_done = done_q;
    assign win_cnt  = cnt_q;

`ifdef REQ_GNT_SVA_EN
    property p_req_to_grant;
        @(posedge clk) disable iff (!rst_n)
            req |=> ##1 grant[*MIN_LEN:MAX_LEN];
    endproperty

    property p_done_excl_grant;
        @(posedge clk) disable iff (!rst_n)
            gnt_done |-> !grant;
    endproperty

    property p_rose_needs_req;
        @(posedge clk) disable iff (!rst_n)
            $rose(grant) |-> $past(req, 2);
    endproperty

    a_req_to_grant: assert property (p_req_to_grant)
        else $error("req_gnt_responder: grant window violated at %0t", $time);
    a_done_excl_grant: assert property (p_done_excl_grant)
        else $error("req_gnt_responder: gnt_done with grant at %0t", $time);
    a_rose_needs_req: assert property (p_rose_needs_req)
        else $error("req_gnt_responder: grant rose without req at %0t", $time);

    c_extension: cover property (@(posedge clk) disable iff (!rst_n)
        state_q == S_GRANT && pending_q);
    c_grant_gap: cover property (@(posedge clk) disable iff (!rst_n)
        grant ##1 !grant ##1 grant);
`endif

endmodule
